axi_lite_mem_slv: RTL and testbench

AXI4-Lite slave responder with an internal word-addressed memory. It answers the transactions generated by the AXI master VIP in the example designs, so a bench can run the master stimulus against real RTL instead of a slave VIP. It sits on the AXI port of the block design alongside the passthrough VIP, clocked by `aclk` and reset by `aresetn`.

---
 rtl/axi_lite_pkg.sv | 19 +
 rtl/axi_lite_mem_ram.sv | 29 ++
 rtl/axi_lite_mem_slv.sv | 206 ++++++++++++++++++++
 tb/tb_axi_lite_mem_slv.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared response codes and FSM state types for the AXI4-Lite memory slave
package axi_lite_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

endpackage

// File: rtl/axi_lite_mem_ram.sv
// rtl/axi_lite_mem_ram.sv - simple dual-port RAM, byte-enabled write port, registered read port
module axi_lite_mem_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int RAM_AW = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [RAM_AW-1:0]     waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wbe,
   input  logic                  re,
   input  logic [RAM_AW-1:0]     raddr,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Read samples the old word when the same address is written in the same cycle.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axi_lite_mem_slv.sv
// rtl/axi_lite_mem_slv.sv - AXI4-Lite slave with internal word-addressed memory
module axi_lite_mem_slv
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [ADDR_W-1:0]     s_axi_awaddr,
   input  logic [2:0]            s_axi_awprot,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [DATA_W-1:0]     s_axi_wdata,
   input  logic [DATA_W/8-1:0]   s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ADDR_W-1:0]     s_axi_araddr,
   input  logic [2:0]            s_axi_arprot,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [DATA_W-1:0]     s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready
);

   localparam int NB     = DATA_W / 8;
   localparam int OFF_W  = $clog2(NB);
   localparam int IDX_W  = ADDR_W - OFF_W;
   localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [32:0] DEPTH_L = 33'(DEPTH);

   function automatic logic in_range(input logic [IDX_W-1:0] idx);
      return 33'(idx) < DEPTH_L;
   endfunction

   wr_state_t         wr_state_q, wr_state_d;
   rd_state_t         rd_state_q, rd_state_d;
   logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic              arready_q, arready_d, rvalid_q, rvalid_d;
   resp_t             bresp_q, bresp_d, rresp_q, rresp_d;
   logic              aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [NB-1:0]     wstrb_q, wstrb_d;
   logic              mem_we, mem_re;
   logic [DATA_W-1:0] ram_rdata;

   wire aw_hs = s_axi_awvalid && awready_q;
   wire w_hs  = s_axi_wvalid  && wready_q;
   wire ar_hs = s_axi_arvalid && arready_q;

   // Commit uses whichever of live beat or captured beat is current this cycle.
   wire [ADDR_W-1:0] wr_addr_sel = aw_hs ? s_axi_awaddr : awaddr_q;
   wire [DATA_W-1:0] wr_data_sel = w_hs  ? s_axi_wdata  : wdata_q;
   wire [NB-1:0]     wr_strb_sel = w_hs  ? s_axi_wstrb  : wstrb_q;
   wire [IDX_W-1:0]  wr_idx      = wr_addr_sel[ADDR_W-1:OFF_W];
   wire [IDX_W-1:0]  rd_idx      = s_axi_araddr[ADDR_W-1:OFF_W];
   wire              wr_ok       = in_range(wr_idx);
   wire              rd_ok       = in_range(rd_idx);

   logic unused_ok;
   assign unused_ok = ^{s_axi_awprot, s_axi_arprot, wr_addr_sel[OFF_W-1:0], s_axi_araddr[OFF_W-1:0]};

   always_comb begin
      wr_state_d = wr_state_q;
      awready_d  = awready_q;
      wready_d   = wready_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      aw_cap_d   = aw_cap_q;
      w_cap_d    = w_cap_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      mem_we     = 1'b0;
      case (wr_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               aw_cap_d = 1'b1;
               awaddr_d = s_axi_awaddr;
            end
            if (w_hs) begin
               w_cap_d = 1'b1;
               wdata_d = s_axi_wdata;
               wstrb_d = s_axi_wstrb;
            end
            if (aw_cap_d && w_cap_d) begin
               mem_we     = wr_ok;
               wr_state_d = W_RESP;
               bvalid_d   = 1'b1;
               bresp_d    = wr_ok ? RESP_OKAY : RESP_SLVERR;
               awready_d  = 1'b0;
               wready_d   = 1'b0;
               aw_cap_d   = 1'b0;
               w_cap_d    = 1'b0;
            end else begin
               awready_d = !aw_cap_d;
               wready_d  = !w_cap_d;
            end
         end
         W_RESP: begin
            if (s_axi_bready) begin
               wr_state_d = W_IDLE;
               bvalid_d   = 1'b0;
               awready_d  = 1'b1;
               wready_d   = 1'b1;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      arready_d  = arready_q;
      rvalid_d   = rvalid_q;
      rresp_d    = rresp_q;
      mem_re     = 1'b0;
      case (rd_state_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (ar_hs) begin
               mem_re     = rd_ok;
               rd_state_d = R_DATA;
               rvalid_d   = 1'b1;
               rresp_d    = rd_ok ? RESP_OKAY : RESP_SLVERR;
               arready_d  = 1'b0;
            end
         end
         R_DATA: begin
            if (s_axi_rready) begin
               rd_state_d = R_IDLE;
               rvalid_d   = 1'b0;
               arready_d  = 1'b1;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state_q <= W_IDLE;
         rd_state_q <= R_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rresp_q    <= RESP_OKAY;
         aw_cap_q   <= 1'b0;
         w_cap_q    <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         aw_cap_q   <= aw_cap_d;
         w_cap_q    <= w_cap_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
      end
   end

   axi_lite_mem_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .RAM_AW (RAM_AW)
   ) u_ram (
      .clk   (aclk),
      .we    (mem_we),
      .waddr (wr_idx[RAM_AW-1:0]),
      .wdata (wr_data_sel),
      .wbe   (wr_strb_sel),
      .re    (mem_re),
      .raddr (rd_idx[RAM_AW-1:0]),
      .rdata (ram_rdata)
   );

   // Data is forced to zero outside a valid OKAY beat, which also covers reset and SLVERR.
   assign s_axi_rdata   = (rvalid_q && rresp_q == RESP_OKAY) ? ram_rdata : '0;
   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_mem_slv.sv
// tb/tb_axi_lite_mem_slv.sv - self-checking bench for axi_lite_mem_slv against an array memory model
module tb_axi_lite_mem_slv;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 256;

   logic              aclk;
   logic              aresetn;
   logic [ADDR_W-1:0] s_axi_awaddr;
   logic [2:0]        s_axi_awprot;
   logic              s_axi_awvalid;
   logic              s_axi_awready;
   logic [DATA_W-1:0] s_axi_wdata;
   logic [3:0]        s_axi_wstrb;
   logic              s_axi_wvalid;
   logic              s_axi_wready;
   logic [1:0]        s_axi_bresp;
   logic              s_axi_bvalid;
   logic              s_axi_bready;
   logic [ADDR_W-1:0] s_axi_araddr;
   logic [2:0]        s_axi_arprot;
   logic              s_axi_arvalid;
   logic              s_axi_arready;
   logic [DATA_W-1:0] s_axi_rdata;
   logic [1:0]        s_axi_rresp;
   logic              s_axi_rvalid;
   logic              s_axi_rready;

   int checks = 0;
   int errors = 0;
   logic [31:0] model [DEPTH];

   axi_lite_mem_slv #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awprot  (s_axi_awprot),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arprot  (s_axi_arprot),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge aclk);
      @(negedge aclk);
   endtask

   function automatic logic [1:0] exp_resp(input logic [ADDR_W-1:0] a);
      return (int'(a) / 4 < DEPTH) ? 2'b00 : 2'b10;
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [ADDR_W-1:0] a);
      return (int'(a) / 4 < DEPTH) ? model[int'(a) / 4] : 32'h0;
   endfunction

   task automatic model_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
      int idx;
      idx = int'(a) / 4;
      if (idx < DEPTH)
         for (int b = 0; b < 4; b++)
            if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
   endtask

   task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input string tag);
      bit aw_p, w_p, aw_now, w_now;
      int n;
      s_axi_awaddr = a;  s_axi_wdata = d;  s_axi_wstrb = s;
      s_axi_awvalid = 1'b1;  s_axi_wvalid = 1'b1;
      aw_p = 1;  w_p = 1;  n = 0;
      while ((aw_p || w_p) && n < 20) begin
         aw_now = aw_p && s_axi_awready;
         w_now  = w_p && s_axi_wready;
         cycle();
         n++;
         if (aw_now) begin aw_p = 0; s_axi_awvalid = 1'b0; end
         if (w_now)  begin w_p = 0;  s_axi_wvalid = 1'b0; end
      end
      if (aw_p || w_p) begin
         chk({tag, "_hs_timeout"}, 0, 1);
         s_axi_awvalid = 1'b0;  s_axi_wvalid = 1'b0;
         return;
      end
      chk({tag, "_bvalid_lat"}, s_axi_bvalid, 1);
      chk({tag, "_bresp"}, s_axi_bresp, exp_resp(a));
      model_write(a, d, s);
      s_axi_bready = 1'b1;
      cycle();
      s_axi_bready = 1'b0;
      chk({tag, "_bvalid_clr"}, s_axi_bvalid, 0);
      chk({tag, "_awready_back"}, s_axi_awready, 1);
   endtask

   task automatic axi_read(input logic [ADDR_W-1:0] a, input string tag, output logic [31:0] got);
      int n;
      got = '0;
      s_axi_araddr = a;
      s_axi_arvalid = 1'b1;
      n = 0;
      while (!s_axi_arready && n < 20) begin
         cycle();
         n++;
      end
      if (!s_axi_arready) begin
         chk({tag, "_ar_timeout"}, 0, 1);
         s_axi_arvalid = 1'b0;
         return;
      end
      cycle();
      s_axi_arvalid = 1'b0;
      chk({tag, "_rvalid_lat"}, s_axi_rvalid, 1);
      chk({tag, "_rresp"}, s_axi_rresp, exp_resp(a));
      chk({tag, "_rdata"}, s_axi_rdata, exp_rdata(a));
      got = s_axi_rdata;
      s_axi_rready = 1'b1;
      cycle();
      s_axi_rready = 1'b0;
      chk({tag, "_rvalid_clr"}, s_axi_rvalid, 0);
      chk({tag, "_arready_back"}, s_axi_arready, 1);
   endtask

   initial begin
      logic [31:0] got, old, d;
      logic [ADDR_W-1:0] a;
      logic [3:0] s;

      aresetn = 1'b0;
      s_axi_awaddr = '0;  s_axi_awprot = '0;  s_axi_awvalid = 1'b0;
      s_axi_wdata = '0;   s_axi_wstrb = '0;   s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b0;
      s_axi_araddr = '0;  s_axi_arprot = '0;  s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b0;
      repeat (3) cycle();

      // Reset state and ready rise after release
      chk("rst_awready", s_axi_awready, 0);
      chk("rst_wready", s_axi_wready, 0);
      chk("rst_arready", s_axi_arready, 0);
      chk("rst_bvalid", s_axi_bvalid, 0);
      chk("rst_rvalid", s_axi_rvalid, 0);
      chk("rst_bresp", s_axi_bresp, 0);
      chk("rst_rresp", s_axi_rresp, 0);
      chk("rst_rdata", s_axi_rdata, 0);
      aresetn = 1'b1;
      chk("rel_awready_pre", s_axi_awready, 0);
      cycle();
      chk("rel_awready", s_axi_awready, 1);
      chk("rel_wready", s_axi_wready, 1);
      chk("rel_arready", s_axi_arready, 1);

      // Initialise words 0..31 so later reads have known contents
      for (int i = 0; i < 32; i++) axi_write(12'(i * 4), $urandom, 4'hF, "init");

      axi_write(12'h010, 32'hDEADBEEF, 4'hF, "wr_beef");
      axi_read(12'h010, "rd_beef", got);
      chk("beef_value", got, 32'hDEADBEEF);

      axi_write(12'h020, 32'h11223344, 4'hF, "wr_full");
      axi_write(12'h020, 32'hAA000000, 4'h8, "wr_strb8");
      axi_read(12'h020, "rd_strb", got);
      chk("strb_merge_value", got, 32'hAA223344);

      // W presented three cycles before AW
      s_axi_wdata = 32'hCAFE0004;  s_axi_wstrb = 4'hF;  s_axi_wvalid = 1'b1;
      cycle();
      s_axi_wvalid = 1'b0;
      chk("wfirst_wready_drop", s_axi_wready, 0);
      chk("wfirst_awready_hold", s_axi_awready, 1);
      cycle();
      cycle();
      chk("wfirst_no_bvalid", s_axi_bvalid, 0);
      s_axi_awaddr = 12'h004;  s_axi_awvalid = 1'b1;
      cycle();
      s_axi_awvalid = 1'b0;
      chk("wfirst_bvalid", s_axi_bvalid, 1);
      chk("wfirst_bresp", s_axi_bresp, 0);
      model_write(12'h004, 32'hCAFE0004, 4'hF);
      s_axi_bready = 1'b1;
      cycle();
      s_axi_bready = 1'b0;
      axi_read(12'h004, "wfirst_rd", got);

      // Out-of-range address
      old = model[0];
      axi_write(12'h400, 32'h55555555, 4'hF, "oor_wr");
      axi_read(12'h400, "oor_rd", got);
      chk("oor_rdata_zero", got, 0);
      axi_read(12'h000, "oor_word0", got);
      chk("oor_word0_kept", got, old);

      // Zero strobe leaves memory untouched
      axi_write(12'h014, 32'h0BADF00D, 4'h0, "zstrb_wr");
      axi_read(12'h014, "zstrb_rd", got);

      // B back-pressure with a concurrent read
      s_axi_awaddr = 12'h018;  s_axi_wdata = 32'h13572468;  s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1;    s_axi_wvalid = 1'b1;
      cycle();
      s_axi_awvalid = 1'b0;    s_axi_wvalid = 1'b0;
      model_write(12'h018, 32'h13572468, 4'hF);
      for (int i = 0; i < 5; i++) begin
         chk("bp_bvalid", s_axi_bvalid, 1);
         chk("bp_bresp", s_axi_bresp, 0);
         chk("bp_awready", s_axi_awready, 0);
         chk("bp_wready", s_axi_wready, 0);
         if (i == 2) axi_read(12'h010, "bp_rd", got);
         else cycle();
      end
      chk("bp_bvalid_end", s_axi_bvalid, 1);
      s_axi_bready = 1'b1;
      cycle();
      s_axi_bready = 1'b0;
      chk("bp_bvalid_clr", s_axi_bvalid, 0);
      axi_read(12'h018, "bp_rd_back", got);

      // Same word read and written in one cycle returns pre-write data
      old = model[3];
      d = $urandom;
      s_axi_awaddr = 12'h00C;  s_axi_wdata = d;  s_axi_wstrb = 4'hF;
      s_axi_araddr = 12'h00C;
      s_axi_awvalid = 1'b1;  s_axi_wvalid = 1'b1;  s_axi_arvalid = 1'b1;
      cycle();
      s_axi_awvalid = 1'b0;  s_axi_wvalid = 1'b0;  s_axi_arvalid = 1'b0;
      chk("coll_bvalid", s_axi_bvalid, 1);
      chk("coll_rvalid", s_axi_rvalid, 1);
      chk("coll_rdata_old", s_axi_rdata, old);
      model_write(12'h00C, d, 4'hF);
      s_axi_bready = 1'b1;  s_axi_rready = 1'b1;
      cycle();
      s_axi_bready = 1'b0;  s_axi_rready = 1'b0;
      axi_read(12'h00C, "coll_rd_new", got);

      // Randomised mix of in-range and out-of-range traffic
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) a = 12'($urandom_range(1024, 4095));
         else a = 12'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
         s = 4'($urandom);
         if ($urandom_range(0, 1) == 0) axi_write(a, $urandom, s, "rnd_wr");
         else axi_read(a, "rnd_rd", got);
      end

      // Reset asserted while a read response is pending
      s_axi_araddr = 12'h010;  s_axi_arvalid = 1'b1;
      cycle();
      s_axi_arvalid = 1'b0;
      chk("mrst_rvalid_pre", s_axi_rvalid, 1);
      #2 aresetn = 1'b0;
      #1;
      chk("mrst_rvalid", s_axi_rvalid, 0);
      chk("mrst_arready", s_axi_arready, 0);
      chk("mrst_awready", s_axi_awready, 0);
      chk("mrst_wready", s_axi_wready, 0);
      @(negedge aclk);
      aresetn = 1'b1;
      chk("mrst_arready_rel", s_axi_arready, 0);
      cycle();
      chk("mrst_arready_back", s_axi_arready, 1);
      chk("mrst_awready_back", s_axi_awready, 1);
      chk("mrst_wready_back", s_axi_wready, 1);
      axi_read(12'h010, "mrst_rd", got);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
